// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
//   Shared encodings for the pipelined barrel shifter (shift_pipe).
//   Contents:
//     OP_W                       width of the operation selector
//     op_t                       operation selector type
//     OP_SLL/OP_SRL/OP_SRA/OP_ROL  operation encodings
//   OP_ROL only rotates when the build defines SHIFT_ROTATE_EN. Otherwise the
//   encoding still travels through the pipe and produces a zero result.
// ---------------------------------------------------------------------------
package shift_pkg;

    localparam int OP_W = 2;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_SLL = 2'b00;
    localparam op_t OP_SRL = 2'b01;
    localparam op_t OP_SRA = 2'b10;
    localparam op_t OP_ROL = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// ---------------------------------------------------------------------------
// shift_stage
//   One pipeline stage of the barrel shifter. The stage applies a fixed shift
//   of DIST (a power of two) when bit log2(DIST) of the carried shift amount
//   is set, then registers the result. The registered shamt, op and tag
//   travel on to the next stage.
//
//   Build option: SHIFT_ROTATE_EN adds the rotate-left path for OP_ROL.
//   Without it, OP_ROL produces zero and the rotate mux is absent.
//
//   Ports:
//     clock, reset_n   rising-edge clock, asynchronous active-low reset
//     in_valid/ready   upstream handshake
//     in_data/shamt/op/tag   incoming operand and its sideband
//     out_valid/ready  downstream handshake
//     out_data/shamt/op/tag  registered result and its sideband
//
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   The stage is ready when it is empty or when the next stage will take its
//   current item (in_ready = !out_valid || out_ready). Because of this, an
//   empty slot is refilled immediately and bubbles collapse. A stalled stage
//   holds every field unchanged.
// ---------------------------------------------------------------------------
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1,
    parameter int TAG_W = 5
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  op_t                      in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(WIDTH)-1:0] out_shamt,
    output op_t                      out_op,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int SHW = $clog2(WIDTH);
    localparam int BIT = $clog2(DIST);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   shamt_q;
    op_t              op_q;
    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] shifted;
    logic             step;

    assign step = in_shamt[BIT];

    // An arithmetic shift keeps the MSB, so each stage's MSB still holds the
    // original sign bit. That lets every stage sign-fill from its own input.
    always_comb begin
        shifted = in_data;
        case (in_op)
            OP_SLL: if (step) shifted = in_data << DIST;
            OP_SRL: if (step) shifted = in_data >> DIST;
            OP_SRA: if (step) shifted = $unsigned($signed(in_data) >>> DIST);
`ifdef SHIFT_ROTATE_EN
            OP_ROL: if (step) shifted = {in_data[WIDTH-DIST-1:0], in_data[WIDTH-1 -: DIST]};
`endif
            default: shifted = '0;
        endcase
    end

    assign in_ready = !valid_q || out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            op_q    <= '0;
            tag_q   <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q  <= shifted;
                shamt_q <= in_shamt;
                op_q    <= in_op;
                tag_q   <= in_tag;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_shamt = shamt_q;
    assign out_op    = op_q;
    assign out_tag   = tag_q;

endmodule

// File: rtl/shift_pipe.sv
// ---------------------------------------------------------------------------
// shift_pipe
//   Pipelined barrel shifter for the execute path. It provides SLL, SRL and
//   SRA by a variable amount, plus ROL when built with SHIFT_ROTATE_EN.
//   Without that option, op 11 returns zero with normal timing.
//
//   Structure: log2(WIDTH) shift_stage instances. Stage k shifts by 2^k.
//   The latency is log2(WIDTH) cycles and the pipe accepts one item per
//   clock. A sideband tag travels with each result.
//
//   Ports:
//     clock, reset_n   rising-edge clock, asynchronous active-low reset
//     in_valid/in_ready     producer handshake (in_ready = stage-0 ready)
//     in_data, in_shamt, in_op, in_tag   operand, amount, op, sideband tag
//     out_valid/out_ready   consumer handshake
//     out_data, out_tag     result and its tag (held while stalled)
//
//   Handshake: a transfer happens on a rising edge where valid && ready.
//   ready_k = !valid_k || ready_{k+1}, and the last ready is out_ready.
// ---------------------------------------------------------------------------
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [OP_W-1:0]          in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int SHW = $clog2(WIDTH);

    // Index k is the input of stage k. Index SHW is the pipe output.
    logic             s_valid [0:SHW];
    logic             s_ready [0:SHW];
    logic [WIDTH-1:0] s_data  [0:SHW];
    logic [SHW-1:0]   s_shamt [0:SHW];
    op_t              s_op    [0:SHW];
    logic [TAG_W-1:0] s_tag   [0:SHW];

    assign s_valid[0]   = in_valid;
    assign s_data[0]    = in_data;
    assign s_shamt[0]   = in_shamt;
    assign s_op[0]      = in_op;
    assign s_tag[0]     = in_tag;
    assign in_ready     = s_ready[0];
    assign s_ready[SHW] = out_ready;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k),
            .TAG_W (TAG_W)
        ) u_stage (
            .clock     (clock),
            .reset_n   (reset_n),
            .in_valid  (s_valid[k]),
            .in_ready  (s_ready[k]),
            .in_data   (s_data[k]),
            .in_shamt  (s_shamt[k]),
            .in_op     (s_op[k]),
            .in_tag    (s_tag[k]),
            .out_valid (s_valid[k+1]),
            .out_ready (s_ready[k+1]),
            .out_data  (s_data[k+1]),
            .out_shamt (s_shamt[k+1]),
            .out_op    (s_op[k+1]),
            .out_tag   (s_tag[k+1])
        );
    end

    assign out_valid = s_valid[SHW];
    assign out_data  = s_data[SHW];
    assign out_tag   = s_tag[SHW];

    // Shamt and op have no consumer once every stage has used them.
    logic unused_tail;
    assign unused_tail = ^{s_shamt[SHW], s_op[SHW]};

endmodule

// File: tb/tb_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_shift_pipe
//   Bench for shift_pipe with WIDTH=32 and TAG_W=5. Directed vectors carry
//   hand-computed expected results. A short random stream is checked against
//   an operator-level model.
//   Expected {tag,data} pairs go into exp_q when the driver sees an accept.
//   A negedge monitor pops and compares each result the DUT delivers.
//   Honours SHIFT_ROTATE_EN in the same way as the RTL build.
// ---------------------------------------------------------------------------
module tb_shift_pipe;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int SHW   = 5;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    // ---------------- scoreboard state ----------------
    logic [TAG_W+WIDTH-1:0] exp_q[$];
    int                     iss_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int last_lat = 0;
    int last_out_cyc = 0;
    int last_iss_cyc = 0;
    int stall_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic [TAG_W-1:0] prev_tag;

    always @(negedge clock) begin
        if (reset_n) begin
            if (stall_prev)
                check("stall_hold", {31'd0, out_valid, 27'd0, out_tag, out_data},
                      {31'd0, 1'b1, 27'd0, prev_tag, prev_data});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got tag %0h data %0h expected none", out_tag, out_data);
                end else begin
                    check("result", {27'd0, out_tag, out_data}, {27'd0, exp_q.pop_front()});
                    last_lat     = cyc - iss_q.pop_front();
                    last_out_cyc = cyc;
                end
                n_out++;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tag   = out_tag;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Call just after a rising edge. The task returns just after the edge
    // that accepted the item.
    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] d,
                         input logic [SHW-1:0] s, input logic [TAG_W-1:0] t,
                         input logic [WIDTH-1:0] e);
        int waited;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = s;
        in_tag   = t;
        waited   = 0;
        forever begin
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back({t, e});
                iss_q.push_back(cyc);
                last_iss_cyc = cyc;
                break;
            end
            waited++;
            stall_cnt++;
            if (waited > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: got in_ready 0 for %0d cycles expected accept", waited);
                break;
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            iss_q.delete();
        end
        tick();
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] d,
                                               input logic [SHW-1:0] s);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00: r = d << s;
            2'b01: r = d >> s;
            2'b10: r = $unsigned($signed(d) >>> s);
`ifdef SHIFT_ROTATE_EN
            default: r = (d << s) | (d >> (6'd32 - {1'b0, s}));
`else
            default: r = '0;
`endif
        endcase
        return r;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int first_iss;
        int outs_before;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        check("rst_out_tag", {59'd0, out_tag}, 64'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        @(negedge clock);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        tick();

        // 1: SLL by 8 and its latency
        issue(2'b00, 32'h0000_00FF, 5'd8, 5'd3, 32'h0000_FF00);
        wait_drain();
        check("latency", 64'(last_lat), 64'd5);

        // 2 and 5: directed corner vectors, issued back to back
        issue(2'b10, 32'h8000_0000, 5'd31, 5'd1, 32'hFFFF_FFFF);
        issue(2'b01, 32'h8000_0000, 5'd31, 5'd2, 32'h0000_0001);
        issue(2'b00, 32'hDEAD_BEEF, 5'd0,  5'd4, 32'hDEAD_BEEF);
        issue(2'b10, 32'h8000_1234, 5'd0,  5'd5, 32'h8000_1234);
        issue(2'b10, 32'h8000_0000, 5'd4,  5'd6, 32'hF800_0000);
        issue(2'b01, 32'hF000_000F, 5'd4,  5'd7, 32'h0F00_0000);
        issue(2'b00, 32'h0000_0001, 5'd31, 5'd8, 32'h8000_0000);
        issue(2'b10, 32'h7FFF_FFFF, 5'd31, 5'd9, 32'h0000_0000);
        issue(2'b00, 32'h1234_5678, 5'd4,  5'd10, 32'h2345_6780);
        issue(2'b01, 32'h1234_5678, 5'd16, 5'd11, 32'h0000_1234);
        issue(2'b10, 32'hF0F0_0000, 5'd8,  5'd12, 32'hFFF0_F000);
`ifdef SHIFT_ROTATE_EN
        issue(2'b11, 32'h8000_0001, 5'd4,  5'd13, 32'h0000_0018);
        issue(2'b11, 32'h1234_5678, 5'd8,  5'd14, 32'h3456_7812);
        issue(2'b11, 32'hCAFE_F00D, 5'd0,  5'd15, 32'hCAFE_F00D);
`else
        issue(2'b11, 32'h8000_0001, 5'd4,  5'd13, 32'h0000_0000);
        issue(2'b11, 32'h1234_5678, 5'd8,  5'd14, 32'h0000_0000);
        issue(2'b11, 32'hCAFE_F00D, 5'd0,  5'd15, 32'h0000_0000);
`endif
        wait_drain();

        // 3: back-to-back stream of 20, one result per clock
        stall_cnt = 0;
        first_iss = 0;
        for (int i = 0; i < 20; i++) begin
            logic [1:0]       op;
            logic [WIDTH-1:0] d;
            logic [SHW-1:0]   s;
            op = 2'($urandom_range(0, 3));
            d  = $urandom;
            s  = 5'($urandom_range(0, 31));
            issue(op, d, s, 5'(i), model(op, d, s));
            if (i == 0) first_iss = last_iss_cyc;
        end
        wait_drain();
        check("stream_stalls", 64'(stall_cnt), 64'd0);
        check("stream_span", 64'(last_out_cyc - first_iss), 64'd24);

        // 4: output stall for 10 cycles, pipe fills, then drains without loss
        out_ready = 1'b0;
        stall_cnt = 0;
        issue(2'b00, 32'h0000_0003, 5'd1, 5'd20, 32'h0000_0006);
        issue(2'b01, 32'h0000_0F00, 5'd8, 5'd21, 32'h0000_000F);
        issue(2'b10, 32'h8000_0000, 5'd1, 5'd22, 32'hC000_0000);
        issue(2'b00, 32'h0000_0001, 5'd5, 5'd23, 32'h0000_0020);
        issue(2'b01, 32'hFFFF_FFFF, 5'd28, 5'd24, 32'h0000_000F);
        check("fill_stalls", 64'(stall_cnt), 64'd0);
        @(negedge clock);
        check("full_in_ready", {63'd0, in_ready}, 64'd0);
        check("full_out_data", {32'd0, out_data}, 64'h0000_0006);
        tick();
        fork
            issue(2'b00, 32'h0000_00AA, 5'd4, 5'd25, 32'h0000_0AA0);
            begin
                repeat (2) tick();
                @(negedge clock);
                check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                tick();
                repeat (2) tick();
                out_ready = 1'b1;
            end
        join
        issue(2'b10, 32'h8000_00F0, 5'd4, 5'd26, 32'hF800_000F);
        wait_drain();

        // 6: reset with 3 items in flight
        out_ready = 1'b0;
        issue(2'b00, 32'h0000_0011, 5'd1, 5'd27, 32'h0000_0022);
        issue(2'b00, 32'h0000_0022, 5'd1, 5'd28, 32'h0000_0044);
        issue(2'b00, 32'h0000_0033, 5'd1, 5'd29, 32'h0000_0066);
        repeat (3) tick();
        @(negedge clock);
        check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_data", {32'd0, out_data}, 64'd0);
        exp_q.delete();
        iss_q.delete();
        out_ready = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        outs_before = n_out;
        repeat (10) tick();
        check("post_rst_outputs", 64'(n_out - outs_before), 64'd0);
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Pipe still works after the reset
        issue(2'b01, 32'h0001_0000, 5'd16, 5'd30, 32'h0000_0001);
        wait_drain();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
